// File: rtl/zbuf_arbiter.sv
// Round-robin z-buffer port arbiter with lock-chaining.
// Optional BUSY watchdog: define ZBUF_ARB_TIMEOUT_EN.
module zbuf_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DEPTH_BITS     = 24,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DEPTH_BITS-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic                         req_err,
  output logic [DEPTH_BITS-1:0]        req_rdata,
  output logic [GW-1:0]                grant_id,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DEPTH_BITS-1:0]        mem_wdata,
  input  logic [DEPTH_BITS-1:0]        mem_rdata,
  input  logic                         mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] win;
  logic [GW-1:0] cand;
  logic          win_ok;
  logic          lock_held;
  logic          tmo;

`ifdef ZBUF_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  assign tmo = (state == BUSY) && !mem_ack &&
               (cnt == CW'(TIMEOUT_CYCLES - 1));

  // count BUSY cycles spent waiting on memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state != BUSY) begin
      cnt <= '0;
    end else if (!mem_ack) begin
      cnt <= cnt + 1'b1;
    end
  end

  // error flag qualifies the ack of a timed-out request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_err <= 1'b0;
    end else if (tmo) begin
      req_err <= 1'b1;
    end else if (state == RESP) begin
      req_err <= 1'b0;
    end
  end
`else
  assign tmo     = 1'b0;
  assign req_err = 1'b0;
`endif

  // lock holder first, else first valid after last_grant
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
    cand   = '0;
    if (lock_held && req_valid[grant_id]) begin
      win    = grant_id;
      win_ok = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand = GW'((int'(last_grant) + k) % NUM_REQ);
        if (!win_ok && req_valid[cand]) begin
          win    = cand;
          win_ok = 1'b1;
        end
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (win_ok) state_nx = BUSY;
      BUSY:    if (mem_ack || tmo) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // grant capture, memory request and response datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ack    <= '0;
      req_rdata  <= '0;
      grant_id   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      lock_held  <= 1'b0;
    end else begin
      req_ack <= '0;
      unique case (state)
        IDLE: begin
          if (win_ok) begin
            mem_req    <= 1'b1;
            mem_we     <= req_we[win];
            mem_addr   <= req_addr[int'(win)*ADDR_W +: ADDR_W];
            mem_wdata  <= req_wdata[int'(win)*DEPTH_BITS +: DEPTH_BITS];
            grant_id   <= win;
            last_grant <= win;
            lock_held  <= req_lock[win];
          end else begin
            lock_held  <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            req_rdata <= mem_rdata;
            req_ack   <= NUM_REQ'(1) << grant_id;
          end else if (tmo) begin
            mem_req   <= 1'b0;
            req_ack   <= NUM_REQ'(1) << grant_id;
            lock_held <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/zbuf_arbiter.md
# zbuf_arbiter

- Shares the single z-buffer memory port between `NUM_REQ` raster engines.
- Each engine issues depth reads and writes on its own request port. The arbiter grants one request at a time, round-robin, and forwards it to memory.
- Routes the read data and acknowledge back to the winning engine.
- Supports lock-chaining, so a depth-test read followed by its write-back executes atomically.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥1).
- `DEPTH_BITS`, 24: depth word width.
- `ADDR_W`, 32: z-buffer address width.
- `TIMEOUT_CYCLES`, 255: watchdog limit (used only with the macro below).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are `clk` and `rst_n`.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NUM_REQ  per-requester request; held until its `req_ack`
- `req_we`  in  NUM_REQ  1 = write, 0 = read
- `req_lock`  in  NUM_REQ  keep grant for this requester's next request
- `req_addr`  in  NUM_REQ*ADDR_W  packed; requester i occupies `[i*ADDR_W +: ADDR_W]`
- `req_wdata`  in  NUM_REQ*DEPTH_BITS  packed, same scheme
- `req_ack`  out  NUM_REQ  one-cycle completion pulse, one-hot
- `req_err`  out  1  qualifies `req_ack`: transaction timed out
- `req_rdata`  out  DEPTH_BITS  read data, valid with `req_ack`
- `grant_id`  out  $clog2(NUM_REQ) (min 1)  index of current/last grantee
- `mem_req`  out  1  memory request, held until `mem_ack`
- `mem_we`, `mem_addr`, `mem_wdata`  out  1/ADDR_W/DEPTH_BITS  registered copies of the granted request
- `mem_rdata`  in  DEPTH_BITS  memory read data, valid with `mem_ack`
- `mem_ack`  in  1  memory completion

## Operation
State machine: IDLE, BUSY, RESP.

- **IDLE: pick a winner.**
  - If a lock is held and its holder's `req_valid`=1, that holder wins.
  - Otherwise the winner is the first set `req_valid` bit searching from `last_grant+1` modulo NUM_REQ.
  - On a win, register we/addr/wdata, set `grant_id`, `last_grant`, and lock-holder = `req_lock[winner]`, then go to BUSY.
  - If there is no winner, stay in IDLE.
- **BUSY:**
  - `mem_req`=1 with constant fields.
  - On `mem_ack`: capture `mem_rdata` into `req_rdata`, drop `mem_req`, go to RESP.
- **RESP:**
  - `req_ack[grant_id]`=1 for exactly one cycle, then go to IDLE.
  - `req_rdata` holds until the next RESP.
  - For writes, `req_rdata` is the value returned by memory, don't-care to requesters.

Boundary conditions:
- **Lock release:**
  - A lock releases when the holder issues a request with `req_lock`=0; that request is still served under the lock.
  - A lock also releases when the holder's `req_valid`=0 in IDLE, and normal round-robin resumes in that same cycle.
- **Stray `mem_ack`:** `mem_ack` while not in BUSY is ignored.
- **Early `req_valid` drop:** a requester dropping `req_valid` during BUSY is a protocol violation. The transaction still completes and is acknowledged.
- **Reset mid-transaction:**
  - All registers return to reset values and `mem_req` drops immediately.
  - The memory side discards the abandoned request.
- **Reset values:**
  - `req_ack`=0, `req_err`=0, `req_rdata`=0, `grant_id`=0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `last_grant`=NUM_REQ-1, so port 0 has first priority; no lock held.
- **NUM_REQ=1:** behaves as a registered pass-through.

## Timing
- **Latency:** request sampled in IDLE at edge t → `mem_req` high from t+1. `mem_ack` at cycle k (earliest k=t+1) → `req_ack` high cycle k+1 → IDLE at k+2.
- **Throughput:** minimum 3 cycles per transaction.
- **Next request:** a requester sees `req_ack` in RESP and may present a new request for the following IDLE cycle.
- **Registered paths:** all outputs are registered; no combinational path from `req_*` or `mem_*` inputs to outputs.

## Configuration
`ZBUF_ARB_TIMEOUT_EN` compiles in a BUSY-state watchdog.

With the macro defined:
- A counter clears on entry to BUSY and increments each BUSY cycle without `mem_ack`.
- When it reaches `TIMEOUT_CYCLES`, the arbiter drops `mem_req` and enters RESP with `req_err`=1 and `req_rdata` unchanged.
- The lock is released.

Without the macro:
- BUSY waits indefinitely.
- `req_err` is tied 0 and no counter exists.

## Test plan
- **Single read:** req_valid=0001, addr 0x100, `mem_ack` 2 cycles after `mem_req` with rdata 0x00ABCD → `mem_addr`=0x100, `mem_we`=0; `req_ack`=0001 one cycle with `req_rdata`=0x00ABCD.
- **Round-robin:** all four requesters valid continuously, no locks → grant order 0,1,2,3,0; each `req_ack` one-hot.
- **Lock chain:** req 2 reads with lock=1 then writes 0x000010 with lock=0 while reqs 0,1 stay valid → req 2 gets back-to-back grants (read, then write of 0x000010); next grant is 3 if valid, else 0.
- **Lock abandon:** req 1 lock=1 then drops `req_valid` → next IDLE grants req 2 (other requesters valid).
- **Reset in BUSY:** assert `rst_n`=0 while `mem_req`=1 → `mem_req`=0 immediately; after release, port 0 wins first.
- **Timeout (macro on, TIMEOUT_CYCLES=8):** never ack → `mem_req` drops after 8 BUSY cycles; `req_ack` pulse with `req_err`=1; stray late `mem_ack` ignored.
